winograd_kernel_scheduler: RTL and testbench

Sequences batch kernel pre-transformation for the Winograd F(4x4,3x3) convolution path. Fetches N 3x3 kernels (16-bit signed) from kernel memory and presents each to kernel_transform_unit. Waits for the unit's transform_done handshake, snapshots the 6x6 result and streams it into the transformed-kernel buffer. Sits between the layer-config FSM and the KTU/transformed-kernel buffer pair.

---
 rtl/winograd_pkg.sv | 23 ++
 rtl/winograd_kernel_scheduler_tile_writer.sv | 55 +++++
 rtl/winograd_kernel_scheduler.sv | 139 +++++++++++++
 tb/tb_winograd_kernel_scheduler.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/winograd_pkg.sv
// Shared types and constants for the Winograd F(4x4,3x3) kernel pre-transform path.
package winograd_pkg;

    localparam int KERNEL_TAPS = 9;
    localparam int TILE_ELEMS  = 36;
    localparam int KERNEL_DIM  = 3;
    localparam int TILE_DIM    = 6;
    localparam int ELEM_W      = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_WRITE,
        S_NEXT,
        S_FINISH
    } wks_state_t;

    typedef logic [0:KERNEL_DIM-1][0:KERNEL_DIM-1][ELEM_W-1:0] kernel3x3_t;
    typedef logic [0:TILE_DIM-1][0:TILE_DIM-1][ELEM_W-1:0]     tile6x6_t;

endpackage

// File: rtl/winograd_kernel_scheduler_tile_writer.sv
// wks_tile_writer: snapshots one 6x6 transformed tile and streams it row-major
// into the transformed-kernel buffer under a ready/valid handshake.
module wks_tile_writer
    import winograd_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int TADDR_W = 12
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          load,
    input  logic                                          abort,
    input  logic [0:TILE_DIM-1][0:TILE_DIM-1][DATA_W-1:0] tile,
    input  logic [TADDR_W-1:0]                            base_addr,
    input  logic                                          wr_ready,
    output logic                                          wr_en,
    output logic [TADDR_W-1:0]                            wr_addr,
    output logic [DATA_W-1:0]                             wr_data,
    output logic                                          last
);

    // Flat row-major view: element 0 is tile[0][0], element 35 is tile[5][5].
    logic [0:TILE_ELEMS-1][DATA_W-1:0] snap;
    logic [5:0]                        ecnt;
    logic                              active;

    assign wr_en   = active;
    assign wr_addr = base_addr + TADDR_W'(ecnt);
    assign wr_data = snap[ecnt];
    assign last    = active && wr_ready && (ecnt == 6'(TILE_ELEMS - 1));

    // Snapshot on load, then advance one element per accepted write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap   <= '0;
            ecnt   <= '0;
            active <= 1'b0;
        end else if (abort) begin
            active <= 1'b0;
            ecnt   <= '0;
        end else if (load) begin
            snap   <= tile;
            ecnt   <= '0;
            active <= 1'b1;
        end else if (active && wr_ready) begin
            if (last) begin
                active <= 1'b0;
                ecnt   <= '0;
            end else begin
                ecnt   <= ecnt + 6'd1;
            end
        end
    end

endmodule

// File: rtl/winograd_kernel_scheduler.sv
// winograd_kernel_scheduler: fetches N 3x3 kernels, hands each to the kernel
// transform unit, and streams the 6x6 results into the transformed buffer.
// Optional watchdog on the KTU handshake: define WKS_TIMEOUT_EN.
module winograd_kernel_scheduler
    import winograd_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int MAX_KERNELS    = 64,
    parameter int KCNT_W         = $clog2(MAX_KERNELS + 1),
    parameter int KADDR_W        = $clog2(MAX_KERNELS * 9),
    parameter int TADDR_W        = $clog2(MAX_KERNELS * 36),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic                                          abort,
    input  logic [KCNT_W-1:0]                             num_kernels,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          error,
    output logic [KCNT_W-1:0]                             kernel_idx,
    output logic                                          kmem_rd_en,
    output logic [KADDR_W-1:0]                            kmem_rd_addr,
    input  logic [DATA_W-1:0]                             kmem_rd_data,
    output logic [0:2][0:2][DATA_W-1:0]                   ktu_kernel,
    input  logic [0:5][0:5][DATA_W-1:0]                   ktu_result,
    input  logic                                          ktu_done,
    output logic                                          tbuf_wr_en,
    output logic [TADDR_W-1:0]                            tbuf_wr_addr,
    output logic [DATA_W-1:0]                             tbuf_wr_data,
    input  logic                                          tbuf_wr_ready
);

    wks_state_t                          state, state_nxt;
    logic [KCNT_W-1:0]                   count;
    logic [3:0]                          fcnt;
    logic [0:KERNEL_TAPS-1][DATA_W-1:0]  kreg;
    logic                                accept, bad_count, wr_last, tile_load;
    logic                                timeout_hit, timeout_fire;

    assign accept     = (state == S_IDLE) && start && !abort;
    assign bad_count  = num_kernels > KCNT_W'(MAX_KERNELS);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_FINISH);
    assign kmem_rd_en = (state == S_FETCH) && (fcnt < 4'(KERNEL_TAPS));
    assign kmem_rd_addr = KADDR_W'(kernel_idx) * KADDR_W'(KERNEL_TAPS) + KADDR_W'(fcnt);
    assign ktu_kernel = kreg;
    assign tile_load  = (state == S_WAIT_DONE) && (state_nxt == S_WRITE);

    // Next-state: abort overrides everything, including the watchdog exit.
    always_comb begin
        state_nxt    = state;
        timeout_fire = 1'b0;
        case (state)
            S_IDLE:      if (start) state_nxt = (num_kernels == '0 || bad_count) ? S_FINISH : S_FETCH;
            S_FETCH:     if (fcnt == 4'(KERNEL_TAPS)) state_nxt = S_WAIT_ACK;
            S_WAIT_ACK:  if (!ktu_done) state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (ktu_done) state_nxt = S_WRITE;
            S_WRITE:     if (wr_last) state_nxt = S_NEXT;
            S_NEXT:      state_nxt = (kernel_idx + KCNT_W'(1) == count) ? S_FINISH : S_FETCH;
            S_FINISH:    state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
        if (timeout_hit && state_nxt == state) begin
            state_nxt    = S_FINISH;
            timeout_fire = 1'b1;
        end
        if (abort) state_nxt = S_IDLE;
    end

    // State register, batch bookkeeping and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            count      <= '0;
            kernel_idx <= '0;
            fcnt       <= '0;
            error      <= 1'b0;
        end else begin
            state <= state_nxt;
            fcnt  <= (state == S_FETCH && state_nxt == S_FETCH) ? fcnt + 4'd1 : 4'd0;
            if (accept) begin
                count      <= num_kernels;
                kernel_idx <= '0;
                error      <= bad_count;
            end else if (timeout_fire && !abort) begin
                error <= 1'b1;
            end
            if (state == S_NEXT) kernel_idx <= kernel_idx + KCNT_W'(1);
        end
    end

    // Read data lands one cycle after its strobe; tap fcnt-1 is captured at fcnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kreg <= '0;
        end else if (state == S_FETCH && fcnt != 4'd0 && !abort) begin
            kreg[fcnt - 4'd1] <= kmem_rd_data;
        end
    end

`ifdef WKS_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCNT_W-1:0] tcnt;

    assign timeout_hit = (state == S_WAIT_ACK || state == S_WAIT_DONE) &&
                         (tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog restarts on every state change, so each wait gets a full budget.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         tcnt <= '0;
        else if (state_nxt != state)     tcnt <= '0;
        else if (state == S_WAIT_ACK || state == S_WAIT_DONE) tcnt <= tcnt + TCNT_W'(1);
    end
`else
    logic unused_timeout;
    assign timeout_hit    = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    wks_tile_writer #(
        .DATA_W  (DATA_W),
        .TADDR_W (TADDR_W)
    ) u_tile_writer (
        .clk       (clk),
        .rst       (rst),
        .load      (tile_load),
        .abort     (abort),
        .tile      (ktu_result),
        .base_addr (TADDR_W'(kernel_idx) * TADDR_W'(TILE_ELEMS)),
        .wr_ready  (tbuf_wr_ready),
        .wr_en     (tbuf_wr_en),
        .wr_addr   (tbuf_wr_addr),
        .wr_data   (tbuf_wr_data),
        .last      (wr_last)
    );

endmodule

// File: tb/tb_winograd_kernel_scheduler.sv
// Directed bench for winograd_kernel_scheduler with a kernel memory model and a
// simple KTU model (tile = kernel in the top-left 3x3, e-100 elsewhere).
module tb_winograd_kernel_scheduler;

`ifdef WKS_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0, abort = 1'b0;
    logic [6:0]            num_kernels = '0;
    logic                  busy, done, error;
    logic [6:0]            kernel_idx;
    logic                  kmem_rd_en;
    logic [9:0]            kmem_rd_addr;
    logic [15:0]           kmem_rd_data = '0;
    logic [0:2][0:2][15:0] ktu_kernel;
    logic [0:5][0:5][15:0] ktu_result;
    logic                  ktu_done;
    logic                  tbuf_wr_en;
    logic [11:0]           tbuf_wr_addr;
    logic [15:0]           tbuf_wr_data;
    logic                  tbuf_wr_ready;

    winograd_kernel_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_kernels(num_kernels),
        .busy(busy), .done(done), .error(error), .kernel_idx(kernel_idx),
        .kmem_rd_en(kmem_rd_en), .kmem_rd_addr(kmem_rd_addr), .kmem_rd_data(kmem_rd_data),
        .ktu_kernel(ktu_kernel), .ktu_result(ktu_result), .ktu_done(ktu_done),
        .tbuf_wr_en(tbuf_wr_en), .tbuf_wr_addr(tbuf_wr_addr), .tbuf_wr_data(tbuf_wr_data),
        .tbuf_wr_ready(tbuf_wr_ready)
    );

    always #5 clk = ~clk;

    int vecs = 0, errs = 0;
    logic [15:0] mem [0:575];
    logic [9:0]  rd_q[$];
    logic [11:0] wa_q[$];
    logic [15:0] wd_q[$];
    logic        ktu_stuck = 1'b0, prev_rd = 1'b0, rdy_pat_en = 1'b0, stalled = 1'b0;
    logic [3:0]  pat = 4'b1001;
    int          ph = 0, lat = 0;
    logic [11:0] hold_a;
    logic [15:0] hold_d;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] texp(input int k, input int e);
        int i = e / 6, j = e % 6;
        return (i < 3 && j < 3) ? mem[k*9 + i*3 + j] : 16'(e) - 16'd100;
    endfunction

    // Kernel memory: one-cycle read latency.
    always @(posedge clk) if (kmem_rd_en) kmem_rd_data <= mem[kmem_rd_addr];

    // KTU model: drops done when the last tap has been read, raises it 3 cycles later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ktu_done <= 1'b1; lat <= 0; prev_rd <= 1'b0;
        end else begin
            prev_rd <= kmem_rd_en;
            if (ktu_stuck) ktu_done <= 1'b1;
            else if (prev_rd && !kmem_rd_en) begin ktu_done <= 1'b0; lat <= 3; end
            else if (lat != 0) begin lat <= lat - 1; if (lat == 1) ktu_done <= 1'b1; end
        end
    end

    always_comb begin
        ktu_result = '0;
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++)
                ktu_result[i][j] = (i < 3 && j < 3) ? ktu_kernel[i%3][j%3] : 16'(i*6 + j) - 16'd100;
    end

    // Buffer ready: always high, or the 1,0,0,1 pattern.
    initial begin
        tbuf_wr_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rdy_pat_en) begin tbuf_wr_ready = pat[ph]; ph = (ph + 1) % 4; end
            else tbuf_wr_ready = 1'b1;
        end
    end

    // Monitor: log reads and accepted writes; stalled writes must hold addr/data.
    always @(negedge clk) begin
        if (!rst) begin
            if (kmem_rd_en) rd_q.push_back(kmem_rd_addr);
            if (tbuf_wr_en && tbuf_wr_ready) begin
                wa_q.push_back(tbuf_wr_addr); wd_q.push_back(tbuf_wr_data);
            end
            if (stalled && tbuf_wr_en) begin
                chk("stall_addr", 32'(tbuf_wr_addr), 32'(hold_a));
                chk("stall_data", 32'(tbuf_wr_data), 32'(hold_d));
            end
            stalled = tbuf_wr_en && !tbuf_wr_ready;
            hold_a  = tbuf_wr_addr;
            hold_d  = tbuf_wr_data;
        end
    end

    task automatic run_batch(input int n, input logic exp_err, input string tag);
        int cyc = 0;
        int nk  = (n > 64) ? 0 : n;
        rd_q.delete(); wa_q.delete(); wd_q.delete();
        @(negedge clk); num_kernels = 7'(n); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (!done && cyc < 3000) begin @(negedge clk); cyc++; end
        chk({tag, "_done"}, 32'(done), 32'd1);
        if (nk == 0) chk({tag, "_lat"}, 32'(cyc), 32'd0);
        chk({tag, "_err"}, 32'(error), 32'(exp_err));
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_nrd"}, 32'(rd_q.size()), 32'(nk*9));
        chk({tag, "_nwr"}, 32'(wa_q.size()), 32'(nk*36));
        for (int i = 0; i < rd_q.size() && i < nk*9; i++) chk({tag, "_raddr"}, 32'(rd_q[i]), 32'(i));
        for (int i = 0; i < wa_q.size() && i < nk*36; i++) begin
            chk({tag, "_waddr"}, 32'(wa_q[i]), 32'(i));
            chk({tag, "_wdata"}, 32'(wd_q[i]), 32'(texp(i / 36, i % 36)));
        end
    endtask

    initial begin
        int cyc;
        logic [15:0] k0 [0:8] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
        logic [15:0] sob[0:8] = '{16'hFFFF, 16'd0, 16'd1, 16'hFFFE, 16'd0, 16'd2, 16'hFFFF, 16'd0, 16'd1};
        for (int i = 0; i < 576; i++) mem[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rden", 32'(kmem_rd_en), 0);
        chk("rst_wren", 32'(tbuf_wr_en), 0);
        chk("rst_flags", {29'd0, done, error, |ktu_kernel}, 0);
        chk("rst_addr", {kernel_idx, kmem_rd_addr, tbuf_wr_addr}, 0);
        rst = 1'b0;

        // Single centre-tap kernel
        for (int i = 0; i < 9; i++) mem[i] = k0[i];
        run_batch(1, 1'b0, "one");

        // Identity / all-ones / 1..9
        for (int i = 0; i < 9; i++) begin
            mem[i]      = (i % 4 == 0) ? 16'd1 : 16'd0;
            mem[9 + i]  = 16'd1;
            mem[18 + i] = 16'(i + 1);
        end
        run_batch(3, 1'b0, "three");

        // Sobel negatives under a stalling buffer
        for (int i = 0; i < 9; i++) mem[i] = sob[i];
        rdy_pat_en = 1'b1;
        run_batch(1, 1'b0, "stall");
        rdy_pat_en = 1'b0;

        // Empty and oversize batches; the next good start clears error
        run_batch(0, 1'b0, "zero");
        run_batch(65, 1'b1, "over");
        run_batch(1, 1'b0, "clr");

        // start and abort together in IDLE: stays idle
        @(negedge clk); num_kernels = 7'd1; start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        chk("sa_idle", 32'(busy), 0);

        // Abort mid-WRITE of kernel 1
        @(negedge clk); num_kernels = 7'd2; start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!(tbuf_wr_en && kernel_idx == 7'd1) && cyc < 1000) begin @(negedge clk); cyc++; end
        chk("ab_reach", 32'(tbuf_wr_en && kernel_idx == 7'd1), 1);
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("ab_busy", 32'(busy), 0);
        chk("ab_wren", 32'(tbuf_wr_en), 0);
        chk("ab_done", 32'(done), 0);
        chk("ab_err", 32'(error), 0);
        repeat (3) @(negedge clk);
        chk("ab_nodone", 32'(done | busy), 0);
        run_batch(2, 1'b0, "after_ab");

        // Async reset mid-FETCH
        @(negedge clk); num_kernels = 7'd2; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        chk("rf_fetch", 32'(kmem_rd_en), 1);
        #2 rst = 1'b1;
        #1;
        chk("rf_busy", 32'(busy), 0);
        chk("rf_rden", 32'(kmem_rd_en), 0);
        chk("rf_kk", 32'(|ktu_kernel), 0);
        chk("rf_addr", {kernel_idx, kmem_rd_addr, tbuf_wr_addr}, 0);
        @(negedge clk); rst = 1'b0;

`ifdef WKS_TIMEOUT_EN
        // Stuck KTU: watchdog fires 16 cycles into WAIT_ACK
        ktu_stuck = 1'b1;
        @(negedge clk); num_kernels = 7'd1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (kmem_rd_en && cyc < 50) begin @(negedge clk); cyc++; end
        cyc = 0;
        while (!done && cyc < 200) begin @(negedge clk); cyc++; end
        chk("to_cycles", 32'(cyc), 32'd17);
        chk("to_err", 32'(error), 1);
        ktu_stuck = 1'b0;
        @(negedge clk);
        chk("to_idle", 32'(busy), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
